// File: rtl/seq_shift_right_pkg.sv
// seq_shift_right_pkg: shared FSM state encoding and datapath defaults for the right shifter
package seq_shift_right_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int SHAMT_W_DEF = 5;
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/seq_shift_right_if.sv
// seq_shift_right_if: start/done request bundle between execute stage and shifter
interface seq_shift_right_if
   import seq_shift_right_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
);
   logic start;
   logic [WIDTH-1:0] data_in;
   logic [SHAMT_W-1:0] shamt;
   logic arith;
   logic [WIDTH-1:0] data_out;
   logic busy;
   logic done;
   modport master (output start, data_in, shamt, arith, input data_out, busy, done);
   modport slave (input start, data_in, shamt, arith, output data_out, busy, done);
endinterface

// File: rtl/seq_shift_right_sr_stage.sv
// sr_stage: one fixed-amount right shift stage with selectable fill bit
module sr_stage #(
   parameter int WIDTH = 32,
   parameter int AMOUNT = 1
) (
   input logic [WIDTH-1:0] din,
   input logic fill,
   input logic enable,
   output logic [WIDTH-1:0] dout
);
   assign dout = enable ? {{AMOUNT{fill}}, din[WIDTH-1:AMOUNT]} : din;
endmodule

// File: rtl/seq_shift_right.sv
// seq_shift_right: multi-cycle srl/sra, one power-of-two stage per clock, MSB stage first
module seq_shift_right
   import seq_shift_right_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input logic clock,
   input logic reset_n,
   seq_shift_right_if.slave bus
);
   localparam logic [SHAMT_W-1:0] IDX0 = SHAMT_W'(SHAMT_W - 1);
   state_t state;
   logic [SHAMT_W-1:0] idx;
   logic [SHAMT_W-1:0] sh;
   logic ar;
   logic fill;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] stg [SHAMT_W];
   assign fill = ar & bus.data_out[WIDTH-1];
   for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
      sr_stage #(.WIDTH(WIDTH), .AMOUNT(2 ** i)) u_stage (
         .din(bus.data_out),
         .fill(fill),
         .enable(sh[i]),
         .dout(stg[i])
      );
   end
   always_comb begin
      nxt = bus.data_out;
      for (int k = 0; k < SHAMT_W; k++) nxt = (idx == SHAMT_W'(k)) ? stg[k] : nxt;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         bus.data_out <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         idx <= IDX0;
         sh <= '0;
         ar <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  bus.data_out <= bus.data_in;
                  sh <= bus.shamt;
                  ar <= bus.arith;
                  idx <= IDX0;
                  bus.busy <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               bus.data_out <= nxt;
               // exit is taken at idx=0 so the counter never wraps
               idx <= (idx == '0) ? idx : idx - 1'b1;
               if (idx == '0) begin
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_shift_right.sv
// tb_seq_shift_right: directed table plus corner sequences and randomized ops for seq_shift_right
module tb_seq_shift_right;
   typedef struct {
      logic [31:0] d;
      logic [4:0] s;
      logic a;
      logic [31:0] e;
   } vec_t;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int compared = 0;
   int mismatched = 0;
   vec_t tv [12];
   always #5 clock = ~clock;
   seq_shift_right_if bus ();
   seq_shift_right dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic op(input logic [31:0] d, input logic [4:0] s, input logic a, output int n, output logic b1, inout int viol);
      bus.data_in = d;
      bus.shamt = s;
      bus.arith = a;
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      b1 = bus.busy;
      n = 1;
      while (!bus.done && n < 12) begin
         @(posedge clock);
         @(negedge clock);
         if (bus.busy && bus.done) viol++;
         n++;
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, dc, viol;
      logic b1;
      logic [31:0] d, e;
      logic [4:0] s;
      logic a;
      viol = 0;
      tv[0]  = '{32'hF0F01234, 5'd16, 1'b0, 32'h0000F0F0};
      tv[1]  = '{32'hF0F01234, 5'd16, 1'b1, 32'hFFFFF0F0};
      tv[2]  = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
      tv[3]  = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};
      tv[4]  = '{32'h12345678, 5'd4,  1'b1, 32'h01234567};
      tv[5]  = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF};
      tv[6]  = '{32'h00000100, 5'd8,  1'b0, 32'h00000001};
      tv[7]  = '{32'h7FFFFFFF, 5'd1,  1'b1, 32'h3FFFFFFF};
      tv[8]  = '{32'h80000001, 5'd1,  1'b0, 32'h40000000};
      tv[9]  = '{32'h80000000, 5'd7,  1'b1, 32'hFF000000};
      tv[10] = '{32'h12345678, 5'd12, 1'b0, 32'h00012345};
      tv[11] = '{32'hF0000000, 5'd5,  1'b1, 32'hFF800000};
      bus.start = 1'b0;
      bus.data_in = '0;
      bus.shamt = '0;
      bus.arith = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset data_out", bus.data_out, 32'h0);
      chk("reset busy", 32'(bus.busy), 32'h0);
      chk("reset done", 32'(bus.done), 32'h0);
      reset_n = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 12; i++) begin
         op(tv[i].d, tv[i].s, tv[i].a, n, b1, viol);
         chk($sformatf("vec%0d latency", i), 32'(n), 32'd6);
         chk($sformatf("vec%0d busy", i), 32'(b1), 32'd1);
         chk($sformatf("vec%0d result", i), bus.data_out, tv[i].e);
         @(posedge clock);
         @(negedge clock);
         chk($sformatf("vec%0d done pulse", i), 32'(bus.done), 32'd0);
         chk($sformatf("vec%0d hold", i), bus.data_out, tv[i].e);
      end
      bus.data_in = 32'hF0F01234;
      bus.shamt = 5'd16;
      bus.arith = 1'b0;
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus.data_in = 32'h1;
      bus.shamt = 5'd1;
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      n = 3;
      while (!bus.done && n < 12) begin
         @(posedge clock);
         @(negedge clock);
         n++;
      end
      chk("ignored start latency", 32'(n), 32'd6);
      chk("ignored start result", bus.data_out, 32'h0000F0F0);
      dc = 0;
      repeat (8) begin
         @(posedge clock);
         @(negedge clock);
         if (bus.done || bus.busy) dc++;
      end
      chk("ignored start not queued", 32'(dc), 32'd0);
      chk("ignored start hold", bus.data_out, 32'h0000F0F0);
      op(32'h12345678, 5'd4, 1'b1, n, b1, viol);
      chk("b2b first result", bus.data_out, 32'h01234567);
      op(32'h80000000, 5'd31, 1'b0, n, b1, viol);
      chk("b2b no idle gap", 32'(b1), 32'd1);
      chk("b2b second latency", 32'(n), 32'd6);
      chk("b2b second result", bus.data_out, 32'h00000001);
      @(negedge clock);
      bus.data_in = 32'hFFFFFFFF;
      bus.shamt = 5'd4;
      bus.arith = 1'b1;
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async reset data_out", bus.data_out, 32'h0);
      chk("async reset busy", 32'(bus.busy), 32'h0);
      chk("async reset done", 32'(bus.done), 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      dc = 0;
      repeat (10) begin
         @(posedge clock);
         @(negedge clock);
         if (bus.done) dc++;
      end
      chk("no done after reset", 32'(dc), 32'd0);
      op(32'h00000100, 5'd8, 1'b0, n, b1, viol);
      chk("post reset latency", 32'(n), 32'd6);
      chk("post reset result", bus.data_out, 32'h00000001);
      for (int i = 0; i < 1000; i++) begin
         d = $urandom;
         s = 5'($urandom_range(0, 31));
         a = 1'($urandom_range(0, 1));
         e = a ? 32'($signed(d) >>> s) : d >> s;
         op(d, s, a, n, b1, viol);
         chk($sformatf("rand%0d latency", i), 32'(n), 32'd6);
         chk($sformatf("rand%0d result", i), bus.data_out, e);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clock);
            @(negedge clock);
         end
      end
      chk("busy/done exclusive", 32'(viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
